data_memory_ctrl: RTL and testbench

//  Clocked, parametrised data memory for the RV32I core's MEM stage; successor to the combinational word-only data memory.

---
 rtl/dmem_pkg.sv | 62 ++++++
 rtl/dmem_sram.sv | 36 +++
 rtl/data_memory_ctrl.sv | 157 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the data memory controller.
// Defines the controller state type, RV32I load/store funct3 codes and byte-lane functions.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    function automatic logic funct3_valid(input logic [2:0] funct3);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

    // Halfword accesses use addr[1] only and word accesses ignore both low bits.
    function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addrLo);
        logic [3:0] be;
        case (funct3)
            F3_LB, F3_LBU: be = 4'b0001 << addrLo;
            F3_LH, F3_LHU: be = addrLo[1] ? 4'b1100 : 4'b0011;
            F3_LW:         be = 4'b1111;
            default:       be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_LB, F3_LBU: d = {4{wdata[7:0]}};
            F3_LH, F3_LHU: d = {2{wdata[15:0]}};
            default:       d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] addrLo,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{addrLo, 3'b000} +: 8];
        h = addrLo[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LBU:  r = {24'h000000, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LHU:  r = {16'h0000, h};
            F3_LW:   r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // The read register only moves on an enabled load, so it doubles as the held response data.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Clocked RV32I data memory with valid/ready handshake, wait states and error reporting.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned H/W accesses report an error).
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] OOB_DATA    = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t   state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          write_q, write_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    addrLo_q, addrLo_d;
    logic [AW-1:0] index_q, index_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          errFunct3_q, errFunct3_d;
    logic          errMisalign_q, errMisalign_d;
    logic          errRange_q, errRange_d;

    logic [31:0]   wordIdx;
    logic          misalign;
    logic          reqErr;
    logic          sramEn;
    logic [31:0]   sramRdata;

    always_comb begin
        wordIdx = {2'b00, req_addr[31:2]};
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (((req_funct3 == F3_LH) || (req_funct3 == F3_LHU)) && req_addr[0]) ||
                   ((req_funct3 == F3_LW) && (req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    assign reqErr = errFunct3_q | errMisalign_q | errRange_q;

    // Every accepted request passes through WAIT; with zero wait states it leaves on the very next edge.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        funct3_d      = funct3_q;
        addrLo_d      = addrLo_q;
        index_d       = index_q;
        wdata_d       = wdata_q;
        errFunct3_d   = errFunct3_q;
        errMisalign_d = errMisalign_q;
        errRange_d    = errRange_q;
        sramEn        = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d       = req_write;
                    funct3_d      = req_funct3;
                    addrLo_d      = req_addr[1:0];
                    index_d       = req_addr[AW+1:2];
                    wdata_d       = req_wdata;
                    errFunct3_d   = !funct3_valid(req_funct3);
                    errMisalign_d = misalign;
                    errRange_d    = wordIdx >= 32'(DEPTH_WORDS);
                    cnt_d         = 4'(WAIT_STATES);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    sramEn  = !reqErr;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            write_q       <= 1'b0;
            funct3_q      <= 3'b000;
            addrLo_q      <= 2'b00;
            index_q       <= '0;
            wdata_q       <= 32'h0000_0000;
            errFunct3_q   <= 1'b0;
            errMisalign_q <= 1'b0;
            errRange_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            funct3_q      <= funct3_d;
            addrLo_q      <= addrLo_d;
            index_q       <= index_d;
            wdata_q       <= wdata_d;
            errFunct3_q   <= errFunct3_d;
            errMisalign_q <= errMisalign_d;
            errRange_q    <= errRange_d;
        end
    end

    // Reset on the access edge must not let a pending store reach the array.
    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk  (clk),
        .en   (sramEn && !reset),
        .we   (write_q),
        .be   (byte_en(funct3_q, addrLo_q)),
        .addr (index_q),
        .wdata(store_data(funct3_q, wdata_q)),
        .rdata(sramRdata)
    );

    always_comb begin
        rsp_rdata = 32'h0000_0000;
        if (state_q == RESP) begin
            if (errFunct3_q || errMisalign_q) begin
                rsp_rdata = 32'h0000_0000;
            end else if (errRange_q) begin
                rsp_rdata = write_q ? 32'h0000_0000 : OOB_DATA;
            end else if (!write_q) begin
                rsp_rdata = load_ext(funct3_q, addrLo_q, sramRdata);
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && reqErr;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed testbench for data_memory_ctrl: one instance with no wait states, one with three.
// Both share request inputs; expected values are hand-computed constants.
module tb_data_memory_ctrl;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqWrite;
    logic [2:0]  reqFunct3;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        reqReady0, reqReady3;
    logic        rspValid0, rspValid3;
    logic        rspReady0, rspReady3;
    logic [31:0] rspRdata0, rspRdata3;
    logic        rspErr0, rspErr3;

    int testsRun  = 0;
    int failCount = 0;

    data_memory_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .OOB_DATA(32'hDEADBEEF)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady0), .req_write(reqWrite),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid0), .rsp_ready(rspReady0), .rsp_rdata(rspRdata0), .rsp_err(rspErr0)
    );

    data_memory_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .OOB_DATA(32'hDEADBEEF)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid), .req_ready(reqReady3), .req_write(reqWrite),
        .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
        .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_rdata(rspRdata3), .rsp_err(rspErr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Issues one request to both instances and collects each response plus its latency in cycles.
    task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d,
                                 output logic [31:0] rd0, output logic [31:0] e0, output int lat0,
                                 output logic [31:0] rd3, output logic [31:0] e3, output int lat3);
        bit got0, got3;
        got0 = 0; got3 = 0;
        rd0 = 32'h0; e0 = 32'h0; lat0 = -1;
        rd3 = 32'h0; e3 = 32'h0; lat3 = -1;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqFunct3 = f3; reqAddr = a; reqWdata = d;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; reqWrite = ~w; reqFunct3 = 3'b111; reqAddr = 32'hFFFF_FFFC;
        reqWdata = 32'h5A5A_5A5A;
        for (int k = 1; k <= 20; k++) begin
            if (got0 && got3) break;
            @(negedge clk);
            if (!got0 && rspValid0) begin
                got0 = 1; rd0 = rspRdata0; e0 = {31'b0, rspErr0}; lat0 = k;
            end
            if (!got3 && rspValid3) begin
                got3 = 1; rd3 = rspRdata3; e3 = {31'b0, rspErr3}; lat3 = k;
            end
        end
    endtask

    logic [31:0] rd0, e0, rd3, e3;
    int          lat0, lat3;

    initial begin
        reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'b000;
        reqAddr = 32'h0; reqWdata = 32'h0; rspReady0 = 1'b1; rspReady3 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst req_ready0", {31'b0, reqReady0}, 32'h1);
        checkOutput("rst rsp_valid0", {31'b0, rspValid0}, 32'h0);
        checkOutput("rst rsp_rdata0", rspRdata0, 32'h0);
        checkOutput("rst rsp_err0", {31'b0, rspErr0}, 32'h0);
        checkOutput("rst req_ready3", {31'b0, reqReady3}, 32'h1);
        checkOutput("rst rsp_valid3", {31'b0, rspValid3}, 32'h0);
        reset = 1'b0;

        // T1: word store then load, latency 1+W
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h1234_5678, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t1 sw rdata0", rd0, 32'h0);
        checkOutput("t1 sw err0", e0, 32'h0);
        checkOutput("t1 sw lat0", 32'(lat0), 32'd1);
        checkOutput("t1 sw lat3", 32'(lat3), 32'd4);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t1 lw rdata0", rd0, 32'h1234_5678);
        checkOutput("t1 lw err0", e0, 32'h0);
        checkOutput("t1 lw lat0", 32'(lat0), 32'd1);
        checkOutput("t1 lw rdata3", rd3, 32'h1234_5678);

        // T2: byte store into the top lane, sign/zero extended loads
        applyStimulus(1'b1, 3'b000, 32'h13, 32'h1234_56AB, rd0, e0, lat0, rd3, e3, lat3);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t2 lb rdata0", rd0, 32'hFFFF_FFAB);
        checkOutput("t2 lb rdata3", rd3, 32'hFFFF_FFAB);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t2 lbu rdata0", rd0, 32'h0000_00AB);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t2 lw rdata0", rd0, 32'hAB34_5678);
        checkOutput("t2 lw rdata3", rd3, 32'hAB34_5678);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t2 lb lane0", rd0, 32'h0000_0078);

        // T3: halfword store into the upper half
        applyStimulus(1'b1, 3'b001, 32'h22, 32'hCDEF_8001, rd0, e0, lat0, rd3, e3, lat3);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t3 lh rdata0", rd0, 32'hFFFF_8001);
        checkOutput("t3 lh rdata3", rd3, 32'hFFFF_8001);
        applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t3 lhu rdata0", rd0, 32'h0000_8001);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t3 lw upper0", rd0 >> 16, 32'h0000_8001);

        // T4: out-of-range load/store must not alias onto word 0
        applyStimulus(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, rd0, e0, lat0, rd3, e3, lat3);
        applyStimulus(1'b0, 3'b010, 32'd4096, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t4 oob lw err0", e0, 32'h1);
        checkOutput("t4 oob lw rdata0", rd0, 32'hDEAD_BEEF);
        checkOutput("t4 oob lw rdata3", rd3, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 3'b010, 32'd4096, 32'h1111_1111, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t4 oob sw err0", e0, 32'h1);
        checkOutput("t4 oob sw rdata0", rd0, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t4 word0 kept0", rd0, 32'hCAFE_F00D);
        checkOutput("t4 word0 kept3", rd3, 32'hCAFE_F00D);

        // Invalid funct3 beats range: rdata 0, not OOB_DATA
        applyStimulus(1'b0, 3'b011, 32'd4096, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("f3 err0", e0, 32'h1);
        checkOutput("f3 rdata0", rd0, 32'h0);
        applyStimulus(1'b1, 3'b110, 32'h10, 32'hFFFF_FFFF, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("f3 sw err0", e0, 32'h1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("f3 no write0", rd0, 32'hAB34_5678);

        // T5: W=3 with the consumer stalling
        @(negedge clk);
        rspReady3 = 1'b0;
        reqValid = 1'b1; reqWrite = 1'b0; reqFunct3 = 3'b010; reqAddr = 32'h10; reqWdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0; reqAddr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t5 valid3 c%0d", k), {31'b0, rspValid3}, (k >= 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("t5 ready3 c%0d", k), {31'b0, reqReady3}, 32'h0);
            if (k >= 4) checkOutput($sformatf("t5 rdata3 c%0d", k), rspRdata3, 32'hAB34_5678);
        end
        rspReady3 = 1'b1;
        @(negedge clk);
        checkOutput("t5 valid3 done", {31'b0, rspValid3}, 32'h0);
        checkOutput("t5 ready3 done", {31'b0, reqReady3}, 32'h1);

        // T6: misaligned accesses
        applyStimulus(1'b0, 3'b010, 32'h11, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("t6 lw mis err0", e0, 32'h1);
        checkOutput("t6 lw mis rdata0", rd0, 32'h0);
`else
        checkOutput("t6 lw mis err0", e0, 32'h0);
        checkOutput("t6 lw mis rdata0", rd0, 32'hAB34_5678);
`endif
        applyStimulus(1'b0, 3'b001, 32'h13, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("t6 lh mis rdata3", rd3, 32'h0);
`else
        checkOutput("t6 lh mis rdata3", rd3, 32'hFFFF_AB34);
`endif
        applyStimulus(1'b0, 3'b010, 32'd4097, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("t6 mis+oob err0", e0, 32'h1);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("t6 mis+oob rdata0", rd0, 32'h0);
`else
        checkOutput("t6 mis+oob rdata0", rd0, 32'hDEAD_BEEF);
`endif

        // Reset one cycle after accept: W=0 store is already committed, W=3 store is dropped
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b010; reqAddr = 32'h10; reqWdata = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rw ready0", {31'b0, reqReady0}, 32'h1);
        checkOutput("rw ready3", {31'b0, reqReady3}, 32'h1);
        checkOutput("rw valid3", {31'b0, rspValid3}, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd0, e0, lat0, rd3, e3, lat3);
        checkOutput("rw committed0", rd0, 32'h55AA_55AA);
        checkOutput("rw dropped3", rd3, 32'hAB34_5678);
        checkOutput("rw lat3", 32'(lat3), 32'd4);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
